mmio_timer_slave: RTL and testbench
===================================

# mmio_timer_slave

Memory-mapped timer/compare peripheral that sits on the slave side of the core's memory map, beside the data RAM and UART. It answers the master's slave port: write data, address, write select and read select in; read data out. It counts prescaled clock ticks, raises a sticky match flag when the count reaches a compare value, and either auto-reloads or halts. Reads are combinational, so the single-cycle core can issue a load and consume the result in the same cycle.

## Interface
- `DATA_WIDTH`, default 32: register and bus data width.
- `ADDR_WIDTH`, default 7: address bits kept by the memory map. Only `address[4:2]` is decoded (word offset); `address[1:0]` is ignored.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `wd` input, DATA_WIDTH: write data from the memory map.
- `address` input, 32 bits: slave-relative byte address.
- `we` input, 1 bit: write select; the write is captured on the clock edge.
- `re` input, 1 bit: read select.
- `rd` output, DATA_WIDTH: read data; combinational.
- `irq` output, 1 bit: interrupt. Present only when `TIMER_IRQ_EN` is defined.

## Operation
- Register map (word offset, byte address):
  - 0 (0x00) CTRL:
    - bit0 EN: run.
    - bit1 AR: auto-reload.
    - bit3 IE: interrupt enable. Exists only with `TIMER_IRQ_EN`.
  - 1 (0x04) PRESCALE: a tick occurs every PRESCALE+1 clocks.
  - 2 (0x08) COUNT: read/write.
  - 3 (0x0C) COMPARE: read/write.
  - 4 (0x10) STATUS:
    - bit0 MATCH: sticky, write-1-to-clear.
    - bit1 OVF: sticky, write-1-to-clear.
- Offsets 5–7: reads return 0; writes are ignored.
- Reads: when `re`=1, `rd` is the selected register. When `re`=0, `rd`=0. Unimplemented bits read 0.
- State machine:
  - IDLE: EN=0. Prescaler is held at 0.
  - RUN: EN=1. The prescaler counts 0..PRESCALE; on reaching PRESCALE it returns to 0 and emits a tick.
  - HALT: one-shot match completed. Hardware clears EN, then the block goes to IDLE on the next cycle.
- Transitions:
  - IDLE→RUN when CTRL is written with EN=1.
  - RUN→IDLE when CTRL is written with EN=0. COUNT is retained; the prescaler is cleared.
  - RUN→HALT on a tick with COUNT==COMPARE and AR=0.
  - HALT→IDLE unconditionally.
- On a tick in RUN:
  - COUNT==COMPARE: set MATCH. If AR=1, COUNT←0. If AR=0, COUNT is held and the block goes to HALT.
  - Otherwise, if COUNT==2^DATA_WIDTH−1: COUNT←0 and OVF is set.
  - Otherwise: COUNT←COUNT+1.
- Arithmetic: unsigned, modulo 2^DATA_WIDTH. The prescaler width equals DATA_WIDTH.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the write wins, and no compare occurs that cycle.
  - A W1C on STATUS in the same cycle as a hardware set of the same bit: the set wins, and the bit stays 1.
  - A CTRL write with EN=1 in the HALT cycle: the write wins, and the next state is RUN.
- Writing PRESCALE while running takes effect at the next prescaler wrap. If the current prescaler value is already greater than the new PRESCALE, the prescaler wraps immediately.

## Timing
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, prescaler=0, state IDLE, `rd`=0 (`re` low), `irq`=0.
- Reset asserted mid-count returns every register to its reset value asynchronously.
- Write latency: a register updates on the edge where `we`=1 and is visible on `rd` in the following cycle.
- Read latency: zero cycles (combinational from `address`/`re`).
- Tick timing: the first tick occurs PRESCALE+1 clocks after the edge that sets EN.
- COUNT changes on the tick edge. MATCH is set on the same edge that sees COUNT==COMPARE.
- `irq` is registered-equivalent: it is a combinational AND of flip-flop outputs, with no extra latency.

## Configuration
- `TIMER_IRQ_EN` defined:
  - CTRL bit3 IE is implemented.
  - Port `irq` = IE & (MATCH | OVF).
- `TIMER_IRQ_EN` undefined:
  - No `irq` port.
  - CTRL bit3 reads 0 and ignores writes.
  - All other behaviour is identical.

## Structure
- Package `timer_pkg`:
  - Word-offset constants CTRL/PRESCALE/COUNT/COMPARE/STATUS.
  - CTRL and STATUS bit-position constants.
  - State enum {IDLE, RUN, HALT}.
  - Reset value of COMPARE.
- Sub-module `timer_prescaler`:
  - Inputs: clk, rst, run, limit.
  - Output: a 1-cycle tick pulse.
  - Clears when run=0.
- The top level holds the register file, the state machine and the read mux.

## Test plan
- Reset: assert rst mid-count. Required: all reads return reset values, COMPARE reads 0xFFFF_FFFF, `irq`=0.
- Prescale 2, COMPARE 3, AR=1, EN=1. Required: COUNT sequence 0,1,2,3,0 with a tick every 3 clocks, MATCH set at the 3→0 tick. Writing STATUS=1 then reads 0.
- One-shot: PRESCALE 0, COMPARE 5, AR=0. Required: COUNT stops at 5, MATCH=1, CTRL.EN reads 0 two cycles after the match, no further increments.
- Overflow: COUNT=0xFFFF_FFFE, COMPARE=0x10, PRESCALE 0. Required: after 2 ticks COUNT=0 and OVF=1.
- Collisions:
  - W1C on MATCH in the cycle MATCH is set by hardware. Required: MATCH remains 1.
  - COUNT write of 7 on a tick edge. Required: COUNT reads 7.
- Bus edges and interrupt:
  - Read offset 6. Required: 0.
  - `re`=0. Required: `rd`=0.
  - With `TIMER_IRQ_EN`, IE=1. Required: `irq` rises with MATCH and falls after W1C.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register word offsets,
// CTRL/STATUS bit positions, FSM state encoding and the COMPARE reset value.
package timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_AR_BIT      = 1;
    localparam int CTRL_IE_BIT      = 3;
    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    // Sliced down to DATA_WIDTH by the user; all ones at any width.
    localparam logic [63:0] COMPARE_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: emits a one-cycle tick every limit+1 clocks while run
// is high, and sits at zero while run is low.
module timer_prescaler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] limit,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        // >= rather than == so a shrunken limit wraps at once instead of counting round.
        tick  = run && (cnt_q >= limit);
        cnt_d = cnt_q + WIDTH'(1);
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer_slave.sv
// Memory-mapped timer/compare slave with combinational reads and a sticky match flag.
// Define TIMER_IRQ_EN to add CTRL.IE and the irq output.
module mmio_timer_slave
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd
`ifdef TIMER_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic [ADDR_WIDTH-1:0] addr_kept;
    logic [2:0]            offset;
    logic                  unused_addr;

    assign addr_kept   = address[ADDR_WIDTH-1:0];
    assign offset      = addr_kept[4:2];
    assign unused_addr = ^{address[31:ADDR_WIDTH], addr_kept[ADDR_WIDTH-1:5], addr_kept[1:0]};

    logic wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;

    assign wr_ctrl     = we && (offset == OFF_CTRL);
    assign wr_prescale = we && (offset == OFF_PRESCALE);
    assign wr_count    = we && (offset == OFF_COUNT);
    assign wr_compare  = we && (offset == OFF_COMPARE);
    assign wr_status   = we && (offset == OFF_STATUS);

    state_e                state_q, state_d;
    logic                  en_q, en_d;
    logic                  ar_q, ar_d;
    logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
`ifdef TIMER_IRQ_EN
    logic                  ie_q, ie_d;
`endif

    logic run;
    logic tick;
    logic hit;
    logic wrap;
    logic halt_clear;

    // A stopping CTRL write suppresses this cycle's tick and clears the prescaler on the same edge.
    assign run = (state_q == RUN) && !(wr_ctrl && !wd[CTRL_EN_BIT]);

    timer_prescaler #(
        .WIDTH (DATA_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .limit (prescale_q),
        .tick  (tick)
    );

    // A software COUNT write owns the cycle: no compare and no overflow.
    assign hit  = tick && !wr_count && (count_q == compare_q);
    assign wrap = tick && !wr_count && !hit && (count_q == '1);

    always_comb begin
        state_d    = state_q;
        halt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ctrl && wd[CTRL_EN_BIT]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wr_ctrl) begin
                    state_d = wd[CTRL_EN_BIT] ? RUN : IDLE;
                end else if (hit && !ar_q) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                halt_clear = 1'b1;
                state_d    = (wr_ctrl && wd[CTRL_EN_BIT]) ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        en_d       = en_q;
        ar_d       = ar_q;
        prescale_d = wr_prescale ? wd : prescale_q;
        compare_d  = wr_compare ? wd : compare_q;
        count_d    = count_q;
`ifdef TIMER_IRQ_EN
        ie_d       = ie_q;
`endif

        if (halt_clear) begin
            en_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d = wd[CTRL_EN_BIT];
            ar_d = wd[CTRL_AR_BIT];
`ifdef TIMER_IRQ_EN
            ie_d = wd[CTRL_IE_BIT];
`endif
        end

        if (wr_count) begin
            count_d = wd;
        end else if (hit) begin
            count_d = ar_q ? '0 : count_q;
        end else if (wrap) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + DATA_WIDTH'(1);
        end

        // Hardware set is OR-ed in after the clear so it wins a same-cycle W1C.
        match_d = (match_q && !(wr_status && wd[STATUS_MATCH_BIT])) || hit;
        ovf_d   = (ovf_q && !(wr_status && wd[STATUS_OVF_BIT])) || wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= COMPARE_RST[DATA_WIDTH-1:0];
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef TIMER_IRQ_EN
            ie_q       <= 1'b0;
`endif
        end else begin
            en_q       <= en_d;
            ar_q       <= ar_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
`ifdef TIMER_IRQ_EN
            ie_q       <= ie_d;
`endif
        end
    end

    logic [DATA_WIDTH-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        case (offset)
            OFF_CTRL: begin
                rd_sel[CTRL_EN_BIT] = en_q;
                rd_sel[CTRL_AR_BIT] = ar_q;
`ifdef TIMER_IRQ_EN
                rd_sel[CTRL_IE_BIT] = ie_q;
`endif
            end
            OFF_PRESCALE: rd_sel = prescale_q;
            OFF_COUNT:    rd_sel = count_q;
            OFF_COMPARE:  rd_sel = compare_q;
            OFF_STATUS: begin
                rd_sel[STATUS_MATCH_BIT] = match_q;
                rd_sel[STATUS_OVF_BIT]   = ovf_q;
            end
            default:      rd_sel = '0;
        endcase
        rd = re ? rd_sel : '0;
    end

`ifdef TIMER_IRQ_EN
    assign irq = ie_q && (match_q || ovf_q);
`endif

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Directed bench for mmio_timer_slave: expected read values go into a scoreboard
// queue when a read is issued and are popped and asserted when rd is sampled.
module tb_mmio_timer_slave;

    localparam int DW = 32;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_PRESCALE = 32'h04;
    localparam logic [31:0] A_COUNT    = 32'h08;
    localparam logic [31:0] A_COMPARE  = 32'h0C;
    localparam logic [31:0] A_STATUS   = 32'h10;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] wd;
    logic [31:0]   address;
    logic          we;
    logic          re;
    logic [DW-1:0] rd;
`ifdef TIMER_IRQ_EN
    logic          irq;
`endif

    always #5 clk = ~clk;

    mmio_timer_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wd      (wd),
        .address (address),
        .we      (we),
        .re      (re),
        .rd      (rd)
`ifdef TIMER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] want;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, want);
        end
    endtask

    // Inputs are driven between clock edges; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [DW-1:0] data);
        address = addr;
        wd      = data;
        we      = 1'b1;
        re      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        we      = 1'b0;
    endtask

    task automatic read_expect(input logic [31:0] addr, input logic en,
                               input logic [DW-1:0] want, input string tag);
        exp_t e;
        address = addr;
        re      = en;
        e.tag   = tag;
        e.want  = want;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check(e.tag, rd, e.want);
        re = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] seq [4];
        logic [DW-1:0] prev;

        rst     = 1'b1;
        we      = 1'b0;
        re      = 1'b0;
        wd      = '0;
        address = '0;
        cycles(2);
        rst = 1'b0;

        // Reset state
        read_expect(A_CTRL,     1'b1, 32'h0, "rst_ctrl");
        read_expect(A_PRESCALE, 1'b1, 32'h0, "rst_prescale");
        read_expect(A_COUNT,    1'b1, 32'h0, "rst_count");
        cycles(1);
        read_expect(A_COMPARE,  1'b1, 32'hFFFF_FFFF, "rst_compare");
        read_expect(A_STATUS,   1'b1, 32'h0, "rst_status");
        read_expect(A_COMPARE,  1'b0, 32'h0, "rst_re_low");
`ifdef TIMER_IRQ_EN
        check("rst_irq", DW'(irq), 32'h0);
`endif
        cycles(1);

        // Prescale 2, compare 3, auto-reload
        bus_write(A_PRESCALE, 32'd2);
        bus_write(A_COMPARE,  32'd3);
        bus_write(A_CTRL,     32'h3);
        read_expect(A_COUNT, 1'b1, 32'd0, "ar_start");
        seq[0] = 32'd1; seq[1] = 32'd2; seq[2] = 32'd3; seq[3] = 32'd0;
        prev = 32'd0;
        for (int i = 0; i < 4; i++) begin
            cycles(2);
            read_expect(A_COUNT, 1'b1, prev, "ar_hold");
            cycles(1);
            read_expect(A_COUNT, 1'b1, seq[i], "ar_tick");
            read_expect(A_STATUS, 1'b1, (i == 3) ? 32'h1 : 32'h0, "ar_match");
            prev = seq[i];
        end
        bus_write(A_CTRL, 32'h0);
        cycles(6);
        read_expect(A_COUNT, 1'b1, 32'd0, "ar_stopped");
        bus_write(A_STATUS, 32'h1);
        read_expect(A_STATUS, 1'b1, 32'h0, "ar_w1c");

        // Shrinking PRESCALE below the running prescaler wraps immediately
        bus_write(A_PRESCALE, 32'd10);
        bus_write(A_COUNT,    32'd0);
        bus_write(A_CTRL,     32'h1);
        cycles(5);
        bus_write(A_PRESCALE, 32'd2);
        read_expect(A_COUNT, 1'b1, 32'd0, "ps_pre");
        cycles(1);
        read_expect(A_COUNT, 1'b1, 32'd1, "ps_wrap_now");
        cycles(2);
        read_expect(A_COUNT, 1'b1, 32'd1, "ps_new_hold");
        cycles(1);
        read_expect(A_COUNT, 1'b1, 32'd2, "ps_new_tick");
        bus_write(A_CTRL, 32'h0);

        // One-shot: PRESCALE 0, COMPARE 5, AR=0
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COMPARE,  32'd5);
        bus_write(A_COUNT,    32'd0);
        bus_write(A_CTRL,     32'h1);
        cycles(5);
        read_expect(A_COUNT,  1'b1, 32'd5, "os_reach");
        read_expect(A_STATUS, 1'b1, 32'h0, "os_pre_match");
        cycles(1);
        read_expect(A_COUNT,  1'b1, 32'd5, "os_hold");
        read_expect(A_STATUS, 1'b1, 32'h1, "os_match");
        cycles(1);
        read_expect(A_CTRL,   1'b1, 32'h0, "os_en_cleared");
        cycles(5);
        read_expect(A_COUNT,  1'b1, 32'd5, "os_stopped");
        bus_write(A_STATUS, 32'h1);

        // CTRL write with EN=1 during HALT re-arms the timer
        bus_write(A_COMPARE, 32'd2);
        bus_write(A_COUNT,   32'd0);
        bus_write(A_CTRL,    32'h1);
        cycles(3);
        read_expect(A_STATUS, 1'b1, 32'h1, "halt_match");
        read_expect(A_COUNT,  1'b1, 32'd2, "halt_count");
        bus_write(A_CTRL, 32'h1);
        read_expect(A_CTRL, 1'b1, 32'h1, "halt_rearm");
        bus_write(A_CTRL, 32'h0);
        read_expect(A_CTRL,  1'b1, 32'h0, "halt_stop");
        read_expect(A_COUNT, 1'b1, 32'd2, "halt_stop_count");
        bus_write(A_STATUS, 32'h1);

        // Overflow, then a COUNT write on a tick edge
        bus_write(A_COMPARE, 32'h10);
        bus_write(A_COUNT,   32'hFFFF_FFFE);
        bus_write(A_CTRL,    32'h1);
        read_expect(A_COUNT,  1'b1, 32'hFFFF_FFFE, "ovf_start");
        cycles(1);
        read_expect(A_COUNT,  1'b1, 32'hFFFF_FFFF, "ovf_max");
        read_expect(A_STATUS, 1'b1, 32'h0, "ovf_pre");
        cycles(1);
        read_expect(A_COUNT,  1'b1, 32'd0, "ovf_wrap");
        read_expect(A_STATUS, 1'b1, 32'h2, "ovf_flag");
        bus_write(A_COUNT, 32'd7);
        read_expect(A_COUNT, 1'b1, 32'd7, "count_wr_on_tick");
        bus_write(A_CTRL, 32'h0);
        read_expect(A_COUNT, 1'b1, 32'd7, "count_after_stop");
        bus_write(A_STATUS, 32'h2);
        read_expect(A_STATUS, 1'b1, 32'h0, "ovf_w1c");

        // W1C of MATCH on the same edge hardware sets it
        bus_write(A_COMPARE, 32'd3);
        bus_write(A_COUNT,   32'd0);
        bus_write(A_CTRL,    32'h3);
        cycles(3);
        read_expect(A_COUNT, 1'b1, 32'd3, "coll_pre");
        bus_write(A_STATUS, 32'h1);
        read_expect(A_STATUS, 1'b1, 32'h1, "coll_set_wins");
        read_expect(A_COUNT,  1'b1, 32'd0, "coll_reload");
        bus_write(A_STATUS, 32'h1);
        read_expect(A_STATUS, 1'b1, 32'h0, "coll_w1c_later");
        bus_write(A_CTRL, 32'h0);

`ifdef TIMER_IRQ_EN
        bus_write(A_COMPARE, 32'd2);
        bus_write(A_COUNT,   32'd0);
        bus_write(A_CTRL,    32'hB);
        check("irq_idle", DW'(irq), 32'h0);
        cycles(3);
        check("irq_rise", DW'(irq), 32'h1);
        bus_write(A_CTRL, 32'h8);
        check("irq_held", DW'(irq), 32'h1);
        read_expect(A_CTRL, 1'b1, 32'h8, "irq_ie_read");
        bus_write(A_STATUS, 32'h1);
        check("irq_fall", DW'(irq), 32'h0);
        bus_write(A_CTRL, 32'h0);
`else
        bus_write(A_CTRL, 32'h8);
        read_expect(A_CTRL, 1'b1, 32'h0, "ctrl_ie_absent");
        bus_write(A_CTRL, 32'hFFFF_FFFE);
        read_expect(A_CTRL, 1'b1, 32'h2, "ctrl_mask");
        bus_write(A_CTRL, 32'h0);
`endif

        // Bus decode edges
        bus_write(A_COMPARE, 32'hA5A5_0003);
        read_expect(32'h0F, 1'b1, 32'hA5A5_0003, "addr_low_bits");
        read_expect(32'h18, 1'b1, 32'h0, "off6_read");
        read_expect(32'h14, 1'b1, 32'h0, "off5_read");
        read_expect(32'h1C, 1'b1, 32'h0, "off7_read");
        bus_write(32'h18, 32'hFFFF_FFFF);
        read_expect(A_COMPARE,  1'b1, 32'hA5A5_0003, "off6_write_ignored");
        read_expect(A_PRESCALE, 1'b1, 32'h0, "off6_prescale_kept");
        read_expect(A_STATUS,   1'b1, 32'h0, "off6_status_kept");
        read_expect(A_COMPARE,  1'b0, 32'h0, "re_low");

        // Reset asserted mid-count
        bus_write(A_PRESCALE, 32'd1);
        bus_write(A_COMPARE,  32'd2);
        bus_write(A_COUNT,    32'd0);
        bus_write(A_CTRL,     32'h3);
        cycles(8);
        read_expect(A_STATUS, 1'b1, 32'h1, "mid_pre_status");
        #1;
        rst = 1'b1;
        #1;
        read_expect(A_COUNT, 1'b1, 32'h0, "mid_async_count");
        cycles(1);
        read_expect(A_CTRL,     1'b1, 32'h0, "mid_rst_ctrl");
        read_expect(A_PRESCALE, 1'b1, 32'h0, "mid_rst_prescale");
        read_expect(A_COMPARE,  1'b1, 32'hFFFF_FFFF, "mid_rst_compare");
        read_expect(A_STATUS,   1'b1, 32'h0, "mid_rst_status");
`ifdef TIMER_IRQ_EN
        check("mid_rst_irq", DW'(irq), 32'h0);
`endif
        cycles(1);
        rst = 1'b0;
        cycles(3);
        read_expect(A_COUNT, 1'b1, 32'h0, "post_rst_count");
        read_expect(A_CTRL,  1'b1, 32'h0, "post_rst_ctrl");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
